// File: rtl/display_pkg.sv
// Shared constants, FSM state type and elaboration helper for the BCD scan display path.
package display_pkg;

  localparam int unsigned BCD_W       = 4;
  localparam logic [3:0]  BCD_BLANK   = 4'hF;
  localparam logic [3:0]  ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } conv_state_t;

  // True when DIGITS decimal digits can hold every DATA_W-bit value (10**digits > 2**data_w).
  function automatic bit digits_fit(input int digits, input int data_w);
    longint unsigned p;
    p = 64'd1;
    if (digits >= 20) return 1'b1;
    for (int i = 0; i < digits; i++) p = p * 64'd10;
    return p > (64'd1 << data_w);
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// load is a strobe: it starts a conversion only in IDLE; while state != IDLE it is ignored, never queued.
module bin2bcd_serial
  import display_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       value_in,
  input  logic                    load,
  output conv_state_t             state,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd
);

  localparam int ACC_W = BCD_W * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  conv_state_t       state_next;
  logic [DATA_W-1:0] shift;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  adj;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = CONV;
      CONV:    if (cnt == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Each nibble is adjusted on its own 4 bits; a nibble never carries into its neighbour.
  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[i*BCD_W +: BCD_W] >= ADD3_THRESH)
        adj[i*BCD_W +: BCD_W] = acc[i*BCD_W +: BCD_W] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == IDLE && load) begin
      shift <= value_in;
      acc   <= '0;
      cnt   <= CNT_W'(DATA_W);
    end else if (state == CONV) begin
      {acc, shift} <= {adj, shift} << 1;
      cnt          <= cnt - CNT_W'(1);
    end
  end

  assign done = (state == DONE);
  assign bcd  = acc;

endmodule

// File: rtl/bcd_scan_driver.sv
// Binary value -> BCD -> time-multiplexed digit scan for a 7-segment decoder.
// Optional LEADING_ZERO_BLANK_EN: blank leading zero digits (digit 0 always shown).
module bcd_scan_driver
  import display_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] value_in,
  input  logic              load,
  output logic              busy,
  output logic [3:0]        digit_bcd,
  output logic [DIGITS-1:0] digit_en
);

  localparam int ACC_W = BCD_W * DIGITS;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (DATA_W < 1 || DATA_W > 16) begin : g_bad_data_w
    $error("bcd_scan_driver: DATA_W must be 1..16");
  end
  if (!digits_fit(DIGITS, DATA_W)) begin : g_bad_digits
    $error("bcd_scan_driver: DIGITS too small for DATA_W");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("bcd_scan_driver: SCAN_DIV must be >= 2");
  end

  conv_state_t      conv_state;
  logic             conv_done;
  logic [ACC_W-1:0] conv_bcd;
  logic [ACC_W-1:0] shown;
  logic [PRE_W-1:0] prescaler;
  logic [IDX_W-1:0] index;
  logic             slot_wrap;
  logic [3:0]       slot_bcd;

  bin2bcd_serial #(
    .DATA_W(DATA_W),
    .DIGITS(DIGITS)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .value_in(value_in),
    .load    (load),
    .state   (conv_state),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  assign busy = (conv_state != IDLE);

  // Whole-word copy on done keeps the scan from ever showing a half-converted value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            shown <= '0;
    else if (conv_done) shown <= conv_bcd;
  end

  assign slot_wrap = (prescaler == PRE_W'(SCAN_DIV - 1));

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank;
  logic              upper_zero;

  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero & (shown[i*BCD_W +: BCD_W] == 4'd0);
      blank[i]   = upper_zero;
    end
    slot_bcd = blank[index] ? BCD_BLANK : shown[index*BCD_W +: BCD_W];
  end
`else
  always_comb begin
    slot_bcd = shown[index*BCD_W +: BCD_W];
  end
`endif

  // Outputs load on the slot wrap, so the first enable appears SCAN_DIV clocks after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      index     <= '0;
      digit_bcd <= BCD_BLANK;
      digit_en  <= '1;
    end else if (slot_wrap) begin
      prescaler <= '0;
      index     <= (index == IDX_W'(DIGITS - 1)) ? '0 : index + IDX_W'(1);
      digit_bcd <= slot_bcd;
      digit_en  <= ~(DIGITS'(1) << index);
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Self-checking bench for bcd_scan_driver: directed plus random loads against a decimal-arithmetic model.
module tb_bcd_scan_driver;

  localparam int DATA_W   = 8;
  localparam int DIGITS   = 3;
  localparam int SCAN_DIV = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] value_in = '0;
  logic              load = 1'b0;
  logic              busy;
  logic [3:0]        digit_bcd;
  logic [DIGITS-1:0] digit_en;

  int checks = 0;
  int errors = 0;

  // Reference model state: edges since reset release, displayed value, pending conversion.
  int                e;
  int                slot;
  int                shown_m;
  int                pend_val;
  int                done_e;
  bit                pending;
  logic [3:0]        exp_bcd;
  logic [DIGITS-1:0] exp_en;

  bcd_scan_driver #(
    .DATA_W  (DATA_W),
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value_in (value_in),
    .load     (load),
    .busy     (busy),
    .digit_bcd(digit_bcd),
    .digit_en (digit_en)
  );

  always #5 clk = ~clk;

  // Decimal digit i of val, with optional leading-zero blanking.
  function automatic logic [3:0] exp_digit(input int val, input int i);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && val < p) return 4'hF;
`endif
    return 4'((val / p) % 10);
  endfunction

  task automatic model_reset();
    e       = 0;
    slot    = 0;
    shown_m = 0;
    pending = 1'b0;
    exp_bcd = 4'hF;
    exp_en  = '1;
  endtask

  task automatic check_outputs(input string tag);
    checks++;
    assert (busy === pending) else begin
      errors++;
      $error("FAIL %s busy got %b exp %b (edge %0d)", tag, busy, pending, e);
    end
    checks++;
    assert (digit_en === exp_en) else begin
      errors++;
      $error("FAIL %s digit_en got %b exp %b (edge %0d)", tag, digit_en, exp_en, e);
    end
    checks++;
    assert (digit_bcd === exp_bcd) else begin
      errors++;
      $error("FAIL %s digit_bcd got %h exp %h (edge %0d)", tag, digit_bcd, exp_bcd, e);
    end
  endtask

  // One clock edge: advance the model using inputs as seen at the edge, then compare.
  task automatic tick(input string tag);
    bit pre_busy;
    @(posedge clk);
    e++;
    pre_busy = pending;
    if (e % SCAN_DIV == 0) begin
      exp_bcd = exp_digit(shown_m, slot);
      exp_en  = ~(DIGITS'(1) << slot);
      slot    = (slot + 1) % DIGITS;
    end
    if (pending && e == done_e) begin
      shown_m = pend_val;
      pending = 1'b0;
    end
    if (load && !pre_busy) begin
      pending  = 1'b1;
      pend_val = int'(value_in);
      done_e   = e + DATA_W + 1;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic do_load(input int v, input string tag);
    value_in = DATA_W'(v);
    load     = 1'b1;
    tick(tag);
    load     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    assert (busy === 1'b0) else begin
      errors++;
      $error("FAIL %s busy got %b exp 0", tag, busy);
    end
    checks++;
    assert (digit_en === '1) else begin
      errors++;
      $error("FAIL %s digit_en got %b exp all ones", tag, digit_en);
    end
    checks++;
    assert (digit_bcd === 4'hF) else begin
      errors++;
      $error("FAIL %s digit_bcd got %h exp f", tag, digit_bcd);
    end
  endtask

  localparam int FULL_SCAN = DIGITS * SCAN_DIV;

  initial begin
    model_reset();
    // Reset held across a few edges, released away from the clock edge.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Idle scan of the reset value, then 255: nine busy cycles, digits 5,5,2.
    run(FULL_SCAN + 2, "idle_scan");
    do_load(255, "load_255");
    run(DATA_W + 1 + 2 * FULL_SCAN, "show_255");

    do_load(0, "load_0");
    run(DATA_W + 1 + 2 * FULL_SCAN, "show_0");

    do_load(7, "load_7");
    run(DATA_W + 1 + 2 * FULL_SCAN, "show_7");

    // Second load during busy (and during DONE) must be dropped.
    do_load(123, "load_123");
    run(2, "busy_123");
    do_load(200, "ignored_200");
    run(DATA_W - 3, "busy_123b");
    do_load(45, "ignored_in_done");
    run(2 * FULL_SCAN, "show_123");

    // Reset in the middle of a conversion: outputs drop at once, value is lost.
    do_load(99, "load_99");
    run(4, "conv_99");
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_async");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(2 * FULL_SCAN + DATA_W, "after_reset");

    // Random values, random idle gaps, random extra loads that may land while busy.
    for (int n = 0; n < 24; n++) begin
      do_load(int'($urandom_range(0, 255)), "rand_load");
      run(int'($urandom_range(1, 12)), "rand_gap");
      if ($urandom_range(0, 1) == 1) do_load(int'($urandom_range(0, 255)), "rand_extra");
      run(int'($urandom_range(DATA_W, 2 * FULL_SCAN)), "rand_run");
    end
    do_load(255, "final_255");
    run(DATA_W + 1 + FULL_SCAN, "final_show");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
